sync_out: RTL
=============

# sync_out

Master-side sync generator: drives the board-to-board sync line that slave boards receive through their `sync_in` synchronizer. While enabled, it emits a periodic, fixed-width high pulse on `sync_out`. It also produces a one-cycle `local_pulse`, delayed so that it lands in the same cycle as the remote receivers' `sync_pulse`. The master's own phase logic uses this pulse, so master and slaves run on a common period boundary.

## Interface
- `PERIOD`, 2500: clk cycles from one `sync_out` rise to the next (40 kHz at 100 MHz). Requires `PERIOD ≥ HIGH_CYCLES + 3`.
- `HIGH_CYCLES`, 250: cycles `sync_out` stays high per period. Requires `2 ≤ HIGH_CYCLES`.
- `LOCAL_DELAY`, 3: cycles from the first high cycle of `sync_out` to `local_pulse`. Range 0..15. The value 3 matches the remote latency (2 synchronizer flops + 1 FSM register).
- `clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous reset, active-high.
- `enable`, in, 1: level; request continuous generation.
- `resync`, in, 1: one-cycle request to start a new period early.
- `sync_out`, out, 1: registered sync line to slave boards.
- `local_pulse`, out, 1: one-cycle aligned period marker.
- `running`, out, 1: high while a period is in progress.

## Operation
- State: FSM {IDLE, HIGH, LOW}; counter `cnt` of width clog2(PERIOD); flag `pending`; delay line of `LOCAL_DELAY` stages.
- "Period start" is the edge that sets `sync_out <= 1`, `cnt <= 0`, state HIGH and `pending <= 0`. It also injects a rise event into the delay line.
- **IDLE:** `sync_out = 0`. If `enable` is sampled 1, a period starts on that edge. `resync` is ignored.
- **HIGH:** `cnt` increments each cycle. On the edge where `cnt == HIGH_CYCLES-1`: `sync_out <= 0` and state goes to LOW.
- **LOW:** `cnt` increments each cycle. On the edge where `cnt == PERIOD-1`:
  - if `enable` = 1, a period starts;
  - otherwise state goes to IDLE and `cnt <= 0`.
- **enable deasserted mid-period:** the current period always completes in full (full high width, full low time). No runt pulses are produced.
- **resync handling:**
  - `resync` = 1 with `enable` = 1 in HIGH or LOW sets `pending`.
  - In LOW, if `pending` is set (or `resync` is 1 that cycle) and `cnt ≥ HIGH_CYCLES+2`, a period starts on that edge. This guarantees at least 3 low cycles before the next rise.
  - `resync` with `enable` = 0 clears `pending`.
- **local_pulse:** equals the rise event delayed by `LOCAL_DELAY` cycles. With `LOCAL_DELAY` = 0 it is high in the first high cycle of `sync_out`. Events already in flight still emerge after `enable` drops.
- **running:** registered, equal to state != IDLE.

## Timing
- Reset values: `sync_out` = 0, `local_pulse` = 0, `running` = 0, state IDLE, `cnt` = 0, `pending` = 0, delay line all 0.
- `rst` takes effect on the next edge from any state. `sync_out` drops that edge and in-flight `local_pulse` events are discarded.
- Start latency: `enable` sampled 1 at edge E makes `sync_out` high in the cycle after E. `running` rises the same cycle.
- Normal period: exactly `HIGH_CYCLES` high cycles, then `PERIOD - HIGH_CYCLES` low cycles.
- Early restart: a resync honored at `cnt = k` gives a period length of `k+1` cycles, with `k ≥ HIGH_CYCLES+2`.
- Simultaneous events:
  - `resync` on the same edge as a natural or early period start is absorbed. `pending` stays 0 and only one rise occurs.
  - `enable` 0→1 together with `resync` in IDLE produces a single start.
  - Repeated `resync` while `pending` is set has no further effect.
- Stop: after the last period ends, `running` falls on the same edge that enters IDLE.
- Alignment: with `LOCAL_DELAY` = 3, the `local_pulse` cycle equals the `sync_pulse` cycle of a `sync_in` on the same clock fed directly from `sync_out`.

## Test plan
All scenarios use `PERIOD` = 20, `HIGH_CYCLES` = 5, `LOCAL_DELAY` = 3.
- **Free-run:** reset, then `enable` = 1 → `sync_out` high 5 / low 15, repeating. First rise is 1 cycle after `enable` is sampled. `local_pulse` is high exactly 3 cycles after each rise. `running` = 1.
- **Graceful stop:** drop `enable` at `cnt` = 2 → the current period finishes (5 high, 15 low), then `sync_out` stays 0. `running` falls at `cnt` = 19. One final `local_pulse` still appears.
- **Early resync:**
  - `resync` at `cnt` = 10 → next rise after that cycle, giving an 11-cycle period.
  - `resync` at `cnt` = 1 (HIGH) → low lasts 3 cycles, giving an 8-cycle period.
- **Boundary resync:** `resync` at `cnt` = 19 → one rise at the normal time, and the following period is the normal 20 cycles.
- **Reset mid-HIGH:** `rst` at `cnt` = 2 → `sync_out` = 0 on the next edge and no `local_pulse` emerges. With `enable` still 1 after `rst` releases, the restart rise occurs 1 cycle after the first post-reset sample.
- **Loopback:** feed `sync_out` into a `sync_in` instance on the same `clk` → its `sync_pulse` coincides with `local_pulse` every period, including early-resync periods.

Source files
------------

// File: rtl/sync_out_if.sv
// Board-to-board sync generator signal bundle: control requests in, sync line and
// local period marker out. The generator uses the master modport.
interface sync_out_if;
    logic enable;
    logic resync;
    logic sync_out;
    logic local_pulse;
    logic running;

    modport master (
        input  enable,
        input  resync,
        output sync_out,
        output local_pulse,
        output running
    );

    modport slave (
        output enable,
        output resync,
        input  sync_out,
        input  local_pulse,
        input  running
    );
endinterface

// File: rtl/sync_out.sv
// Master-side sync generator: periodic fixed-width pulse on the board sync line,
// plus a local period marker delayed to coincide with the slaves' received pulse.
module sync_out #(
    parameter int PERIOD      = 2500,
    parameter int HIGH_CYCLES = 250,
    parameter int LOCAL_DELAY = 3
) (
    input  logic      clk,
    input  logic      rst,
    sync_out_if.master bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    localparam int CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] HIGH_LAST   = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] EARLY_MIN   = CNT_W'(HIGH_CYCLES + 2);

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               pending, pending_next;
    logic               start;
    logic               sync_next, running_next;
    logic               sync_q, running_q;
    logic [LOCAL_DELAY:0] rise_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pending   <= 1'b0;
            sync_q    <= 1'b0;
            running_q <= 1'b0;
            // NOTE: the delay line is reset too, so in-flight rise events are dropped.
            rise_q    <= '0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            pending   <= pending_next;
            sync_q    <= sync_next;
            running_q <= running_next;
            rise_q[0] <= start;
            for (int i = 1; i <= LOCAL_DELAY; i++) begin
                rise_q[i] <= rise_q[i-1];
            end
        end
    end

    // NOTE: every variable gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pending_next = pending;
        start        = 1'b0;

        if (bus.resync) begin
            pending_next = bus.enable && (state != IDLE);
        end

        case (state)
            IDLE: begin
                if (bus.enable) start = 1'b1;
            end
            HIGH: begin
                cnt_next = cnt + CNT_W'(1);
                if (cnt == HIGH_LAST) state_next = LOW;
            end
            LOW: begin
                cnt_next = cnt + CNT_W'(1);
                if (cnt == PERIOD_LAST) begin
                    if (bus.enable) begin
                        start = 1'b1;
                    end else begin
                        state_next   = IDLE;
                        cnt_next     = '0;
                        pending_next = 1'b0;
                    end
                end else if (bus.enable && (pending || bus.resync) && cnt >= EARLY_MIN) begin
                    // Early restart only once at least three low cycles have elapsed.
                    start = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase

        // A period start absorbs any resync arriving on the same edge.
        if (start) begin
            state_next   = HIGH;
            cnt_next     = '0;
            pending_next = 1'b0;
        end
    end

    always_comb begin
        sync_next    = (state_next == HIGH);
        running_next = (state_next != IDLE);
    end

    assign bus.sync_out    = sync_q;
    assign bus.running     = running_q;
    assign bus.local_pulse = rise_q[LOCAL_DELAY];
endmodule
